brick_hit_controller: RTL

- Game-side writer for the display's block-state port. Once per frame it compares the sampled ball box against the 20-block wall (4 rows x 5 columns).
- On the first overlapping live block it advances that block's hit state, issues the single-cycle write (active_write_enable / active_position / active_data) and pulses bounce direction flags to the ball logic.
- It also keeps the score and the count of remaining blocks.
- It is the only writer of the display's block-state table. The display resets its table to 0 when it is reset, and this block's reset is aligned with that reset so both copies start from the same state.

---
 rtl/brick_hit_controller.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/brick_hit_controller.sv
// Per-frame collision scan of the ball box against a 4x5 brick wall.
// It is the single writer of the display's block-state table and also keeps the score and live-block count.
module brick_hit_controller #(
    parameter int BALL_SIZE       = 7,
    parameter int BLOCK_SPACING_X = 40,
    parameter int BLOCK_WIDTH     = 80,
    parameter int BLOCK_HEIGHT    = 30,
    parameter int FIRST_ROW_Y     = 40,
    parameter int ROW_PITCH       = 50,
    parameter int DESTROY_BONUS   = 4
) (
    input  logic        CLK_50MH,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic [9:0]  ball_x,
    input  logic [9:0]  ball_y,
    output logic        busy,
    output logic        active_write_enable,
    output logic [5:0]  active_position,
    output logic [1:0]  active_data,
    output logic        hit_valid,
    output logic        flip_x,
    output logic        flip_y,
    output logic        scan_done,
    output logic [15:0] score,
    output logic [4:0]  blocks_remaining,
    output logic        all_cleared,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_WRITE, S_DONE} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [9:0]  r_ball_x;
    logic [9:0]  r_ball_y;
    logic [4:0]  r_idx;
    logic [1:0]  r_hit [20];

    logic [1:0]  w_row;
    logic [2:0]  w_col;
    logic [10:0] w_bx;
    logic [10:0] w_by;
    logic [10:0] w_xl;
    logic [10:0] w_xr;
    logic [10:0] w_yt;
    logic [10:0] w_yb;
    logic [10:0] w_cx;
    logic        w_overlap;
    logic        w_live;
    logic        w_center;
    logic [16:0] w_score_sum;

    // Row/column of the block under test, without a divider.
    always_comb begin
        w_row = 2'd0;
        w_col = 3'(r_idx);
        if (r_idx >= 5'd15) begin
            w_row = 2'd3;
            w_col = 3'(r_idx - 5'd15);
        end else if (r_idx >= 5'd10) begin
            w_row = 2'd2;
            w_col = 3'(r_idx - 5'd10);
        end else if (r_idx >= 5'd5) begin
            w_row = 2'd1;
            w_col = 3'(r_idx - 5'd5);
        end
    end

    // 11-bit arithmetic keeps ball_x + BALL_SIZE from wrapping near 1023.
    assign w_bx = 11'(BLOCK_SPACING_X) + 11'(w_col) * 11'(BLOCK_SPACING_X + BLOCK_WIDTH);
    assign w_by = 11'(FIRST_ROW_Y) + 11'(w_row) * 11'(ROW_PITCH);
    assign w_xl = {1'b0, r_ball_x};
    assign w_yt = {1'b0, r_ball_y};
    assign w_xr = w_xl + 11'(BALL_SIZE);
    assign w_yb = w_yt + 11'(BALL_SIZE);
    assign w_cx = w_xl + 11'(BALL_SIZE / 2);

    assign w_overlap = (w_xl <= w_bx + 11'(BLOCK_WIDTH)) && (w_xr >= w_bx) &&
                       (w_yt <= w_by + 11'(BLOCK_HEIGHT)) && (w_yb >= w_by);
    assign w_live    = (r_hit[r_idx] != 2'd3);
    assign w_center  = (w_cx >= w_bx) && (w_cx <= w_bx + 11'(BLOCK_WIDTH));

    assign all_cleared = (blocks_remaining == 5'd0);
    assign o_dbg_state = r_state;

    always_comb begin
        w_next              = r_state;
        busy                = (r_state != S_IDLE);
        active_write_enable = 1'b0;
        active_position     = 6'd0;
        active_data         = 2'd0;
        hit_valid           = 1'b0;
        flip_x              = 1'b0;
        flip_y              = 1'b0;
        scan_done           = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (frame_tick) w_next = S_SCAN;
            end
            S_SCAN: begin
                if (w_overlap && w_live) w_next = S_WRITE;
                else if (r_idx == 5'd19) w_next = S_DONE;
            end
            S_WRITE: begin
                active_write_enable = 1'b1;
                hit_valid           = 1'b1;
                active_position     = {1'b0, r_idx};
                active_data         = r_hit[r_idx] + 2'd1;
                flip_y              = w_center;
                flip_x              = !w_center;
                w_next              = S_DONE;
            end
            S_DONE: begin
                scan_done = 1'b1;
                w_next    = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_score_sum = {1'b0, score} +
                         ((active_data == 2'd3) ? 17'(1 + DESTROY_BONUS) : 17'd1);

    always_ff @(posedge CLK_50MH or negedge reset) begin
        if (!reset) begin
            r_state          <= S_IDLE;
            r_ball_x         <= 10'd0;
            r_ball_y         <= 10'd0;
            r_idx            <= 5'd0;
            score            <= 16'd0;
            blocks_remaining <= 5'd20;
            for (int i = 0; i < 20; i++) r_hit[i] <= 2'd0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && frame_tick) begin
                r_ball_x <= ball_x;
                r_ball_y <= ball_y;
                r_idx    <= 5'd0;
            end
            if (r_state == S_SCAN && !(w_overlap && w_live) && r_idx != 5'd19)
                r_idx <= r_idx + 5'd1;
            // Score and block count become visible the cycle after the write strobe.
            if (r_state == S_WRITE) begin
                r_hit[r_idx] <= active_data;
                score        <= w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
                if (active_data == 2'd3) blocks_remaining <= blocks_remaining - 5'd1;
            end
        end
    end

endmodule
